// File: rtl/playback_unit.sv
// Plays back recorded {key, count} words from a synchronous-read memory, holding each key for (count+1)*TICK_DIV cycles.
// Optional macro PLAYBACK_LOOP_EN: wrap to address 1 after the last word instead of finishing.
module playback_unit #(
   parameter int ADDR_W   = 11,
   parameter int KEY_W    = 8,
   parameter int CNT_W    = 4,
   parameter int TICK_DIV = 1
) (
   input  logic                   RCLK,
   input  logic                   nRST,
   input  logic                   PlayEn,
   input  logic [ADDR_W-1:0]      LastAddress,
   input  logic [KEY_W+CNT_W-1:0] ReadData,
   output logic [ADDR_W-1:0]      ReadAddress,
   output logic                   ReadEn,
   output logic [KEY_W-1:0]       Key,
   output logic                   Playing,
   output logic                   Done
);

   // state   | meaning
   // S_IDLE  | waiting for a PlayEn rising edge
   // S_FETCH | read strobe for the word at ReadAddress
   // S_LOAD  | read data valid; capture key and duration
   // S_HOLD  | key driven while the duration counts down
   // S_DONE  | one-cycle completion pulse, key silenced
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_DONE} state_t;

   localparam int                TICK_W    = 16;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [CNT_W:0]    REM_ONE   = (CNT_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [CNT_W:0]      rem_q, rem_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic                play_q;
   logic                start;

   assign start = PlayEn & ~play_q;

   always_ff @(posedge RCLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         key_q   <= '0;
         rem_q   <= '0;
         tick_q  <= '0;
         play_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         key_q   <= key_d;
         rem_q   <= rem_d;
         tick_q  <= tick_d;
         play_q  <= PlayEn;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      key_d   = key_q;
      rem_d   = rem_q;
      tick_d  = tick_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (LastAddress == '0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = ADDR_ONE;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (!PlayEn) begin
               state_d = S_IDLE;
               key_d   = '0;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!PlayEn) begin
               state_d = S_IDLE;
               key_d   = '0;
            end else begin
               key_d   = ReadData[KEY_W+CNT_W-1:CNT_W];
               rem_d   = {1'b0, ReadData[CNT_W-1:0]} + REM_ONE;
               tick_d  = '0;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!PlayEn) begin
               state_d = S_IDLE;
               key_d   = '0;
            end else if (tick_q == TICK_LAST) begin
               tick_d = '0;
               rem_d  = rem_q - REM_ONE;
               // Last unit of this word: LastAddress is compared live, so a lowered value ends early.
               if (rem_q == REM_ONE) begin
`ifdef PLAYBACK_LOOP_EN
                  if (addr_q == LastAddress) begin
                     addr_d  = ADDR_ONE;
                     state_d = S_FETCH;
                  end else
`endif
                  if (addr_q >= LastAddress) begin
                     state_d = S_DONE;
                     key_d   = '0;
                  end else begin
                     addr_d  = addr_q + ADDR_ONE;
                     state_d = S_FETCH;
                  end
               end
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end
         S_DONE: begin
            key_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            key_d   = '0;
         end
      endcase
   end

   assign ReadAddress = addr_q;
   assign ReadEn      = (state_q == S_FETCH);
   assign Key         = key_q;
   assign Playing     = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_HOLD);
   assign Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_playback_unit.sv
// Scoreboard bench for playback_unit: per-cycle expected output traces are queued at stimulus time and popped each cycle.
// Two instances: TICK_DIV=1 (dut1) and TICK_DIV=3 (dut3).
module tb_playback_unit;

   typedef struct packed {
      logic [7:0]  key;
      logic        playing;
      logic        done;
      logic        rd_en;
      logic [10:0] addr;
   } obs_t;

   logic        RCLK = 1'b0;
   logic        nRST = 1'b0;
   logic        play1 = 1'b0, play3 = 1'b0;
   logic [10:0] last1 = '0, last3 = '0;
   logic [11:0] rdata1 = '0, rdata3 = '0;
   logic [10:0] raddr1, raddr3;
   logic        rden1, rden3, playing1, playing3, done1, done3;
   logic [7:0]  key1, key3;
   logic [11:0] mem1 [0:7];
   logic [11:0] mem3 [0:7];
   logic        sel3 = 1'b0;
   obs_t        obs1, obs3, obs_sel;
   obs_t        exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 RCLK = ~RCLK;

   playback_unit #(.ADDR_W(11), .KEY_W(8), .CNT_W(4), .TICK_DIV(1)) dut1 (
      .RCLK(RCLK), .nRST(nRST), .PlayEn(play1), .LastAddress(last1), .ReadData(rdata1),
      .ReadAddress(raddr1), .ReadEn(rden1), .Key(key1), .Playing(playing1), .Done(done1));

   playback_unit #(.ADDR_W(11), .KEY_W(8), .CNT_W(4), .TICK_DIV(3)) dut3 (
      .RCLK(RCLK), .nRST(nRST), .PlayEn(play3), .LastAddress(last3), .ReadData(rdata3),
      .ReadAddress(raddr3), .ReadEn(rden3), .Key(key3), .Playing(playing3), .Done(done3));

   always @(posedge RCLK) begin
      if (rden1) rdata1 <= mem1[raddr1[2:0]];
      if (rden3) rdata3 <= mem3[raddr3[2:0]];
   end

   assign obs1    = {key1, playing1, done1, rden1, raddr1};
   assign obs3    = {key3, playing3, done3, rden3, raddr3};
   assign obs_sel = sel3 ? obs3 : obs1;

   task automatic push_exp(input logic [7:0] k, input logic p, input logic d, input logic re,
                           input logic [10:0] a);
      exp_q.push_back(obs_t'{k, p, d, re, a});
   endtask

   // Expected trace for words 1..n: FETCH and LOAD keep the previous key, then the hold.
   task automatic push_words(input int n, input int tdiv, input bit use3, inout logic [7:0] prev);
      logic [11:0] w;
      for (int a = 1; a <= n; a++) begin
         w = use3 ? mem3[a] : mem1[a];
         push_exp(prev, 1'b1, 1'b0, 1'b1, 11'(a));
         push_exp(prev, 1'b1, 1'b0, 1'b0, 11'(a));
         for (int i = 0; i < (int'(w[3:0]) + 1) * tdiv; i++)
            push_exp(w[11:4], 1'b1, 1'b0, 1'b0, 11'(a));
         prev = w[11:4];
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge RCLK);
      n_checks++;
      if (obs1 !== '0) begin
         n_fail++;
         $display("FAIL reset_dut1: got %h exp 0", obs1);
      end
      n_checks++;
      if (obs3 !== '0) begin
         n_fail++;
         $display("FAIL reset_dut3: got %h exp 0", obs3);
      end
      nRST = 1'b1;
      repeat (2) push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd0);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL reset_idle: got %h exp %h", obs_sel, e);
         end
      end
   endtask

   task automatic test_empty();
      last1 = 11'd0;
      play1 = 1'b1;
      push_exp(8'h00, 1'b0, 1'b1, 1'b0, 11'd0);
      repeat (2) push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd0);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL empty: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      last1 = 11'd2;
      @(negedge RCLK);
   endtask

   task automatic test_basic();
      logic [7:0] prev = 8'h00;
      play1 = 1'b1;
      push_words(2, 1, 1'b0, prev);
      push_exp(8'h00, 1'b0, 1'b1, 1'b0, 11'd2);
      push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd2);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL basic: got %h exp %h", obs_sel, e);
         end
      end
      // PlayEn still high: no restart without a new rising edge
      push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd2);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL basic_no_retrigger: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      @(negedge RCLK);
   endtask

   task automatic test_last_lowered();
      play1 = 1'b1;
      push_exp(8'h00, 1'b1, 1'b0, 1'b1, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL lowered_fetch: got %h exp %h", obs_sel, e);
         end
      end
      last1 = 11'd1;
      push_exp(8'h00, 1'b1, 1'b0, 1'b0, 11'd1);
      repeat (3) push_exp(8'h41, 1'b1, 1'b0, 1'b0, 11'd1);
      push_exp(8'h00, 1'b0, 1'b1, 1'b0, 11'd1);
      push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL lowered: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      last1 = 11'd2;
      @(negedge RCLK);
   endtask

   task automatic test_abort();
      play1 = 1'b1;
      push_exp(8'h00, 1'b1, 1'b0, 1'b1, 11'd1);
      push_exp(8'h00, 1'b1, 1'b0, 1'b0, 11'd1);
      repeat (2) push_exp(8'h41, 1'b1, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL abort_pre: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      repeat (3) push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL abort_post: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b1;
      push_exp(8'h00, 1'b1, 1'b0, 1'b1, 11'd1);
      push_exp(8'h00, 1'b1, 1'b0, 1'b0, 11'd1);
      push_exp(8'h41, 1'b1, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL abort_restart: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL abort_second: got %h exp %h", obs_sel, e);
         end
      end
   endtask

   task automatic test_divider();
      logic [7:0] prev = 8'h00;
      sel3  = 1'b1;
      last3 = 11'd1;
      play3 = 1'b1;
      push_words(1, 3, 1'b1, prev);
      push_exp(8'h00, 1'b0, 1'b1, 1'b0, 11'd1);
      push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL divider: got %h exp %h", obs_sel, e);
         end
      end
      play3 = 1'b0;
      sel3  = 1'b0;
      @(negedge RCLK);
   endtask

   task automatic test_async_reset();
      play1 = 1'b1;
      push_exp(8'h00, 1'b1, 1'b0, 1'b1, 11'd1);
      push_exp(8'h00, 1'b1, 1'b0, 1'b0, 11'd1);
      repeat (2) push_exp(8'h41, 1'b1, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL areset_pre: got %h exp %h", obs_sel, e);
         end
      end
      #2;
      nRST  = 1'b0;
      play1 = 1'b0;
      #1;
      n_checks++;
      if (obs1 !== '0) begin
         n_fail++;
         $display("FAIL areset_immediate: got %h exp 0", obs1);
      end
      @(negedge RCLK);
      nRST = 1'b1;
      repeat (3) push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd0);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL areset_quiet: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b1;
      push_exp(8'h00, 1'b1, 1'b0, 1'b1, 11'd1);
      push_exp(8'h00, 1'b1, 1'b0, 1'b0, 11'd1);
      push_exp(8'h41, 1'b1, 1'b0, 1'b0, 11'd1);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL areset_restart: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      @(negedge RCLK);
   endtask

`ifdef PLAYBACK_LOOP_EN
   task automatic test_loop();
      logic [7:0] prev = 8'h00;
      play1 = 1'b1;
      repeat (3) push_words(2, 1, 1'b0, prev);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL loop: got %h exp %h", obs_sel, e);
         end
      end
      play1 = 1'b0;
      push_exp(8'h00, 1'b0, 1'b0, 1'b0, 11'd2);
      while (exp_q.size() > 0) begin
         obs_t e;
         @(negedge RCLK);
         e = exp_q.pop_front();
         n_checks++;
         if (obs_sel !== e) begin
            n_fail++;
            $display("FAIL loop_stop: got %h exp %h", obs_sel, e);
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) begin
         mem1[i] = '0;
         mem3[i] = '0;
      end
      mem1[1] = {8'h41, 4'd2};
      mem1[2] = {8'h42, 4'd0};
      mem3[1] = {8'h10, 4'd15};
      test_reset();
      test_empty();
`ifndef PLAYBACK_LOOP_EN
      test_basic();
      test_last_lowered();
`endif
      test_abort();
`ifndef PLAYBACK_LOOP_EN
      test_divider();
`endif
      test_async_reset();
`ifdef PLAYBACK_LOOP_EN
      test_loop();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
